// File: rtl/vga_pkg.sv
// Shared VGA-path types: sequencer state encoding, game outcome and coordinate width.
package vga_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCROLL = 3'd1,
        HOLD   = 3'd2,
        WAIT   = 3'd3,
        CLEAR  = 3'd4
    } seq_state_t;

    typedef enum logic {
        OUT_WIN  = 1'b0,
        OUT_LOSE = 1'b1
    } outcome_t;

endpackage

// File: rtl/motion_tick.sv
// Motion pacing: clock divider whose wraps raise a pending flag that is applied at frame start.
module motion_tick #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic frame_start,
    output logic apply
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             wrap;

    assign wrap  = en && (cnt == CNT_W'(TICK_DIV - 1));
    // A wrap coinciding with frame_start is applied immediately, without going through pending.
    assign apply = en && frame_start && (pending || wrap);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            if (apply)
                pending <= 1'b0;
            else if (wrap)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/end_banner_seq.sv
// End-of-game banner sequencer: latches outcome, freezes play, scrolls the banner up,
// holds it, then waits for the player and pulses a restart request.
module end_banner_seq
    import vga_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000000,
    parameter int unsigned START_ROW  = 480,
    parameter int unsigned END_ROW    = 140,
    parameter int unsigned BANNER_COL = 195,
    parameter int unsigned STEP       = 3,
    parameter int unsigned HOLD_TICKS = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               game_win,
    input  logic               game_lose,
    input  logic               restart_btn,
    output logic [COORD_W-1:0] banner_row,
    output logic [COORD_W-1:0] banner_col,
    output logic               show_winner,
    output logic               show_loser,
    output logic               freeze_game,
    output logic               restart_req,
    output logic [2:0]         seq_state
);

    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic signed [COORD_W:0] STEP_S = (COORD_W + 1)'(STEP);
    localparam logic signed [COORD_W:0] END_S  = (COORD_W + 1)'(END_ROW);

    seq_state_t                 state;
    outcome_t                   outcome;
    logic                       banner_on;
    logic [HOLD_W-1:0]          hold_cnt;
    logic                       tick_en;
    logic                       apply;
    logic signed [COORD_W:0]    row_dec;

    assign tick_en = (state == SCROLL) || (state == HOLD) || (state == WAIT);

    motion_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .en         (tick_en),
        .frame_start(frame_start),
        .apply      (apply)
    );

    // One bit of headroom so a step past row 0 compares as negative instead of wrapping.
    assign row_dec = $signed({1'b0, banner_row}) - STEP_S;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            outcome     <= OUT_WIN;
            banner_on   <= 1'b0;
            banner_row  <= COORD_W'(START_ROW);
            hold_cnt    <= '0;
            freeze_game <= 1'b0;
            restart_req <= 1'b0;
        end else begin
            restart_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (game_lose || game_win) begin
                        outcome     <= game_lose ? OUT_LOSE : OUT_WIN;
                        banner_on   <= 1'b1;
                        freeze_game <= 1'b1;
                        state       <= SCROLL;
                    end
                end
                SCROLL: begin
                    if (apply) begin
                        if (row_dec <= END_S) begin
                            banner_row <= COORD_W'(END_ROW);
                            hold_cnt   <= '0;
                            state      <= HOLD;
                        end else begin
                            banner_row <= row_dec[COORD_W-1:0];
                        end
                    end
                end
                HOLD: begin
                    if (apply) begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1))
                            state <= WAIT;
                        else
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                WAIT: begin
                    if (restart_btn) begin
                        restart_req <= 1'b1;
                        banner_row  <= COORD_W'(START_ROW);
                        banner_on   <= 1'b0;
                        outcome     <= OUT_WIN;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    freeze_game <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign banner_col  = COORD_W'(BANNER_COL);
    assign show_winner = banner_on && (outcome == OUT_WIN);
    assign show_loser  = banner_on && (outcome == OUT_LOSE);
    assign seq_state   = state;

endmodule

// File: tb/tb_end_banner_seq.sv
// Directed bench for end_banner_seq with a short tick divider and small row range.
module tb_end_banner_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        game_win = 1'b0;
    logic        game_lose = 1'b0;
    logic        restart_btn = 1'b0;
    logic [11:0] banner_row;
    logic [11:0] banner_col;
    logic        show_winner;
    logic        show_loser;
    logic        freeze_game;
    logic        restart_req;
    logic [2:0]  seq_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    end_banner_seq #(
        .TICK_DIV  (4),
        .START_ROW (20),
        .END_ROW   (10),
        .BANNER_COL(195),
        .STEP      (3),
        .HOLD_TICKS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .game_win   (game_win),
        .game_lose  (game_lose),
        .restart_btn(restart_btn),
        .banner_row (banner_row),
        .banner_col (banner_col),
        .show_winner(show_winner),
        .show_loser (show_loser),
        .freeze_game(freeze_game),
        .restart_req(restart_req),
        .seq_state  (seq_state)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick_clk();
        tick_clk();
        rst = 1'b0;
        n_cmp++; if (seq_state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", seq_state); end
        n_cmp++; if (banner_row !== 12'd20) begin n_bad++; $display("FAIL reset_row got=%0d exp=20", banner_row); end
        n_cmp++; if (banner_col !== 12'd195) begin n_bad++; $display("FAIL reset_col got=%0d exp=195", banner_col); end
        n_cmp++; if ({show_winner, show_loser, freeze_game, restart_req} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0000", {show_winner, show_loser, freeze_game, restart_req});
        end
    endtask

    task automatic test_lose();
        game_lose = 1'b1;
        tick_clk();
        game_lose = 1'b0;
        n_cmp++; if (show_loser !== 1'b1) begin n_bad++; $display("FAIL lose_show_loser got=%b exp=1", show_loser); end
        n_cmp++; if (show_winner !== 1'b0) begin n_bad++; $display("FAIL lose_show_winner got=%b exp=0", show_winner); end
        n_cmp++; if (freeze_game !== 1'b1) begin n_bad++; $display("FAIL lose_freeze got=%b exp=1", freeze_game); end
        n_cmp++; if (seq_state !== 3'd1) begin n_bad++; $display("FAIL lose_state got=%0d exp=1", seq_state); end
        n_cmp++; if (banner_row !== 12'd20) begin n_bad++; $display("FAIL lose_row got=%0d exp=20", banner_row); end
    endtask

    task automatic test_scroll();
        logic [11:0] exp_rows [4] = '{12'd17, 12'd14, 12'd11, 12'd10};
        logic [2:0]  exp_state;
        for (int k = 0; k < 4; k++) begin
            repeat (4) tick_clk();
            frame_start = 1'b1;
            tick_clk();
            frame_start = 1'b0;
            exp_state = (k == 3) ? 3'd2 : 3'd1;
            n_cmp++; if (banner_row !== exp_rows[k]) begin n_bad++; $display("FAIL scroll_row[%0d] got=%0d exp=%0d", k, banner_row, exp_rows[k]); end
            n_cmp++; if (seq_state !== exp_state) begin n_bad++; $display("FAIL scroll_state[%0d] got=%0d exp=%0d", k, seq_state, exp_state); end
        end
    endtask

    task automatic test_hold_restart();
        restart_btn = 1'b1;
        tick_clk();
        restart_btn = 1'b0;
        n_cmp++; if (seq_state !== 3'd2) begin n_bad++; $display("FAIL hold_ignore_btn_state got=%0d exp=2", seq_state); end
        n_cmp++; if (restart_req !== 1'b0) begin n_bad++; $display("FAIL hold_ignore_btn_req got=%b exp=0", restart_req); end
        repeat (3) tick_clk();
        frame_start = 1'b1;
        tick_clk();
        frame_start = 1'b0;
        n_cmp++; if (seq_state !== 3'd2) begin n_bad++; $display("FAIL hold_tick1_state got=%0d exp=2", seq_state); end
        repeat (4) tick_clk();
        frame_start = 1'b1;
        tick_clk();
        frame_start = 1'b0;
        n_cmp++; if (seq_state !== 3'd3) begin n_bad++; $display("FAIL hold_to_wait got=%0d exp=3", seq_state); end
        n_cmp++; if (banner_row !== 12'd10) begin n_bad++; $display("FAIL wait_row got=%0d exp=10", banner_row); end
        restart_btn = 1'b1;
        game_win    = 1'b1;
        tick_clk();
        restart_btn = 1'b0;
        game_win    = 1'b0;
        n_cmp++; if (seq_state !== 3'd4) begin n_bad++; $display("FAIL clear_state got=%0d exp=4", seq_state); end
        n_cmp++; if (restart_req !== 1'b1) begin n_bad++; $display("FAIL clear_req got=%b exp=1", restart_req); end
        n_cmp++; if (banner_row !== 12'd20) begin n_bad++; $display("FAIL clear_row got=%0d exp=20", banner_row); end
        n_cmp++; if ({show_winner, show_loser} !== 2'b00) begin n_bad++; $display("FAIL clear_show got=%b exp=00", {show_winner, show_loser}); end
        n_cmp++; if (freeze_game !== 1'b1) begin n_bad++; $display("FAIL clear_freeze got=%b exp=1", freeze_game); end
        tick_clk();
        n_cmp++; if (seq_state !== 3'd0) begin n_bad++; $display("FAIL post_clear_state got=%0d exp=0", seq_state); end
        n_cmp++; if (restart_req !== 1'b0) begin n_bad++; $display("FAIL post_clear_req got=%b exp=0", restart_req); end
        n_cmp++; if (freeze_game !== 1'b0) begin n_bad++; $display("FAIL post_clear_freeze got=%b exp=0", freeze_game); end
    endtask

    task automatic test_both_outcomes();
        game_win  = 1'b1;
        game_lose = 1'b1;
        tick_clk();
        game_win  = 1'b0;
        game_lose = 1'b0;
        n_cmp++; if ({show_winner, show_loser} !== 2'b01) begin n_bad++; $display("FAIL both_show got=%b exp=01", {show_winner, show_loser}); end
        n_cmp++; if (seq_state !== 3'd1) begin n_bad++; $display("FAIL both_state got=%0d exp=1", seq_state); end
    endtask

    task automatic test_collapsed_ticks();
        repeat (12) tick_clk();
        n_cmp++; if (banner_row !== 12'd20) begin n_bad++; $display("FAIL withheld_row got=%0d exp=20", banner_row); end
        frame_start = 1'b1;
        tick_clk();
        frame_start = 1'b0;
        n_cmp++; if (banner_row !== 12'd17) begin n_bad++; $display("FAIL collapsed_row got=%0d exp=17", banner_row); end
        repeat (3) tick_clk();
        frame_start = 1'b1;
        tick_clk();
        frame_start = 1'b0;
        n_cmp++; if (banner_row !== 12'd14) begin n_bad++; $display("FAIL pre_rst_row got=%0d exp=14", banner_row); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        n_cmp++; if (seq_state !== 3'd0) begin n_bad++; $display("FAIL midrst_state got=%0d exp=0", seq_state); end
        n_cmp++; if (banner_row !== 12'd20) begin n_bad++; $display("FAIL midrst_row got=%0d exp=20", banner_row); end
        n_cmp++; if ({show_winner, show_loser, freeze_game, restart_req} !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_flags got=%b exp=0000", {show_winner, show_loser, freeze_game, restart_req});
        end
        tick_clk();
        n_cmp++; if (restart_req !== 1'b0) begin n_bad++; $display("FAIL midrst_no_req got=%b exp=0", restart_req); end
    endtask

    task automatic test_win_early_frame();
        game_win = 1'b1;
        tick_clk();
        game_win = 1'b0;
        n_cmp++; if ({show_winner, show_loser} !== 2'b10) begin n_bad++; $display("FAIL win_show got=%b exp=10", {show_winner, show_loser}); end
        tick_clk();
        frame_start = 1'b1;
        tick_clk();
        frame_start = 1'b0;
        n_cmp++; if (banner_row !== 12'd20) begin n_bad++; $display("FAIL early_frame_row got=%0d exp=20", banner_row); end
    endtask

    initial begin
        test_reset();
        test_lose();
        test_scroll();
        test_hold_restart();
        test_both_outcomes();
        test_collapsed_ticks();
        test_mid_reset();
        test_win_early_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
